// File: rtl/relu_execution.sv
// Tile-streaming ReLU / copy stage: reads a vector from one buffer tile by tile,
// clamps negatives (or passes through) and writes the tiles to another buffer.
module relu_execution #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_ELEMS = 32,
  parameter int MAX_LEN    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             op_mode,
  input  logic [4:0]                       src_buffer_id,
  input  logic [4:0]                       dest_buffer_id,
  input  logic [9:0]                       length,
  output logic                             done,
  output logic                             busy,
  output logic                             vec_read_enable,
  output logic [4:0]                       vec_read_buffer_id,
  input  logic [DATA_WIDTH*TILE_ELEMS-1:0] vec_read_tile,
  input  logic                             vec_read_valid,
  output logic                             vec_write_enable,
  output logic [4:0]                       vec_write_buffer_id,
  output logic [DATA_WIDTH*TILE_ELEMS-1:0] vec_write_tile
);

  localparam int TILE_W = DATA_WIDTH * TILE_ELEMS;
  localparam int OFF_W  = $clog2(MAX_LEN + TILE_ELEMS);
  localparam int CNT_W  = $clog2(MAX_LEN / TILE_ELEMS + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    COMPLETE
  } state_t;

  state_t            state_reg;
  logic              mode_reg;
  logic [9:0]        length_reg;
  logic [CNT_W-1:0]  tiles_total_reg;
  logic [CNT_W-1:0]  tile_count_reg;
  logic [OFF_W-1:0]  offset_reg;

  logic [OFF_W-1:0]  len_ext;
  logic [OFF_W-1:0]  tiles_calc;
  logic [OFF_W-1:0]  length_reg_ext;
  logic [CNT_W-1:0]  tile_count_next;
  logic [TILE_W-1:0] tile_next;

  assign len_ext         = OFF_W'(length);
  assign tiles_calc      = (len_ext + OFF_W'(TILE_ELEMS - 1)) / OFF_W'(TILE_ELEMS);
  assign length_reg_ext  = OFF_W'(length_reg);
  assign tile_count_next = tile_count_reg + CNT_W'(1);

  // Per-element transform; elements past the vector end are padded with zero.
  genvar gi;
  generate
    for (gi = 0; gi < TILE_ELEMS; gi++) begin : g_elem
      logic signed [DATA_WIDTH-1:0] elem;
      logic [OFF_W-1:0]             idx;
      logic                         in_range;
      logic                         clamp;

      assign elem     = vec_read_tile[gi*DATA_WIDTH +: DATA_WIDTH];
      assign idx      = offset_reg + OFF_W'(gi);
      assign in_range = (idx < length_reg_ext);
      assign clamp    = !mode_reg && elem[DATA_WIDTH-1];
      assign tile_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        (in_range && !clamp) ? elem : {DATA_WIDTH{1'b0}};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg           <= IDLE;
      mode_reg            <= 1'b0;
      length_reg          <= '0;
      tiles_total_reg     <= '0;
      tile_count_reg      <= '0;
      offset_reg          <= '0;
      done                <= 1'b0;
      busy                <= 1'b0;
      vec_read_enable     <= 1'b0;
      vec_read_buffer_id  <= '0;
      vec_write_enable    <= 1'b0;
      vec_write_buffer_id <= '0;
      vec_write_tile      <= '0;
    end else begin
      done             <= 1'b0;
      vec_read_enable  <= 1'b0;
      vec_write_enable <= 1'b0;

      case (state_reg)
        IDLE: begin
          // busy drops one cycle after the done pulse unless a new start lands
          busy <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (length != 10'd0) begin
              mode_reg            <= op_mode;
              length_reg          <= length;
              vec_read_buffer_id  <= src_buffer_id;
              vec_write_buffer_id <= dest_buffer_id;
              tiles_total_reg     <= tiles_calc[CNT_W-1:0];
              tile_count_reg      <= '0;
              offset_reg          <= '0;
              vec_read_enable     <= 1'b1;
              state_reg           <= WAIT_DATA;
            end else begin
              state_reg <= COMPLETE;
            end
          end
        end

        WAIT_DATA: begin
          if (vec_read_valid) begin
            vec_write_tile   <= tile_next;
            vec_write_enable <= 1'b1;
            tile_count_reg   <= tile_count_next;
            offset_reg       <= offset_reg + OFF_W'(TILE_ELEMS);
            // Next request rides alongside this write so only one read is ever in flight
            if (tile_count_next < tiles_total_reg) begin
              vec_read_enable <= 1'b1;
            end else begin
              state_reg <= COMPLETE;
            end
          end
        end

        COMPLETE: begin
          done      <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_execution.sv
// Randomized bench for relu_execution: a buffer-controller model answers reads
// with random latency and every written tile is compared against a reference.
module tb_relu_execution;
  localparam int DW = 8;
  localparam int TE = 32;
  localparam int TW = DW * TE;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          op_mode;
  logic [4:0]    src_buffer_id;
  logic [4:0]    dest_buffer_id;
  logic [9:0]    length;
  logic          done;
  logic          busy;
  logic          vec_read_enable;
  logic [4:0]    vec_read_buffer_id;
  logic [TW-1:0] vec_read_tile;
  logic          vec_read_valid;
  logic          vec_write_enable;
  logic [4:0]    vec_write_buffer_id;
  logic [TW-1:0] vec_write_tile;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  relu_execution #(.DATA_WIDTH(DW), .TILE_ELEMS(TE), .MAX_LEN(1024)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .op_mode             (op_mode),
    .src_buffer_id       (src_buffer_id),
    .dest_buffer_id      (dest_buffer_id),
    .length              (length),
    .done                (done),
    .busy                (busy),
    .vec_read_enable     (vec_read_enable),
    .vec_read_buffer_id  (vec_read_buffer_id),
    .vec_read_tile       (vec_read_tile),
    .vec_read_valid      (vec_read_valid),
    .vec_write_enable    (vec_write_enable),
    .vec_write_buffer_id (vec_write_buffer_id),
    .vec_write_tile      (vec_write_tile)
  );

  task automatic check_eq(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Reference: element idx of the vector is kept only if idx < len, and in ReLU
  // mode only if it is non-negative.
  function automatic logic [TW-1:0] ref_tile(input logic [TW-1:0] src, input int t,
                                             input int len, input bit mode);
    logic [TW-1:0] res;
    res = '0;
    for (int i = 0; i < TE; i++) begin
      int idx;
      int v;
      int r;
      idx = t * TE + i;
      v   = int'($signed(src[i*DW +: DW]));
      if (idx >= len)          r = 0;
      else if (!mode && v < 0) r = 0;
      else                     r = v;
      res[i*DW +: DW] = r[DW-1:0];
    end
    return res;
  endfunction

  function automatic int pick_lat(input int sel, input int n);
    if (sel == 0) return 2;
    if (sel == 1) return (n % 3 == 0) ? 1 : ((n % 3 == 1) ? 3 : 5);
    return int'($urandom_range(1, 4));
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_done"}, TW'(done), '0);
    check_eq({tag, "_busy"}, TW'(busy), '0);
    check_eq({tag, "_rd_en"}, TW'(vec_read_enable), '0);
    check_eq({tag, "_wr_en"}, TW'(vec_write_enable), '0);
    check_eq({tag, "_rd_id"}, TW'(vec_read_buffer_id), '0);
    check_eq({tag, "_wr_id"}, TW'(vec_write_buffer_id), '0);
    check_eq({tag, "_wr_tile"}, vec_write_tile, '0);
  endtask

  // Entered right after a negedge; leaves right after a negedge.
  task automatic run_op(input int len, input bit mode, input logic [4:0] src,
                        input logic [4:0] dst, input int lat_sel, input bit pattern,
                        input bit spurious_start, input bit reset_mid);
    logic [TW-1:0] srcq[$];
    logic [TW-1:0] expq[$];
    int  pat[11] = '{-5, 3, -128, 127, 0, -1, 8, -9, 2, 4, 99};
    int  tiles, rd_n, wr_n, pending, start_cyc, valid_cyc, last_wr_cyc, iter;
    bit  outstanding, got_done, spur_done, new_rd;

    tiles = (len + TE - 1) / TE;
    for (int t = 0; t < tiles; t++) begin
      logic [TW-1:0] tile;
      for (int i = 0; i < TE; i++) begin
        int k;
        logic [DW-1:0] b;
        k = int'($urandom_range(0, 7));
        if (k == 0)      b = 8'h80;
        else if (k == 1) b = 8'h7f;
        else if (k == 2) b = 8'h00;
        else             b = DW'($urandom);
        if (pattern && t == 0 && i < 11) b = pat[i][DW-1:0];
        tile[i*DW +: DW] = b;
      end
      srcq.push_back(tile);
      expq.push_back(ref_tile(tile, t, len, mode));
    end

    $display("op: len=%0d mode=%0d src=%0d dst=%0d tiles=%0d lat_sel=%0d",
             len, mode, src, dst, tiles, lat_sel);

    start          = 1'b1;
    op_mode        = mode;
    src_buffer_id  = src;
    dest_buffer_id = dst;
    length         = 10'(len);
    start_cyc      = cyc;
    rd_n = 0; wr_n = 0; pending = 0; outstanding = 0; got_done = 0; spur_done = 0;
    valid_cyc = -100; last_wr_cyc = -100; iter = 0;

    while (!got_done && iter < 3000) begin
      tick();
      iter++;
      start = 1'b0;
      new_rd = 1'b0;
      check_eq("busy_high", TW'(busy), TW'(1));

      if (vec_write_enable) begin
        check_eq("wr_id", TW'(vec_write_buffer_id), TW'(dst));
        check_eq("wr_after_valid", TW'(cyc), TW'(valid_cyc + 1));
        if (wr_n < tiles) check_eq("wr_tile", vec_write_tile, expq[wr_n]);
        else              check_eq("extra_write", TW'(1), TW'(0));
        wr_n++;
        last_wr_cyc = cyc;
      end

      if (vec_read_enable) begin
        check_eq("one_outstanding", TW'(outstanding), TW'(0));
        check_eq("rd_id", TW'(vec_read_buffer_id), TW'(src));
        if (rd_n == 0) check_eq("first_rd_latency", TW'(cyc), TW'(start_cyc + 1));
        if (rd_n >= tiles) check_eq("extra_read", TW'(1), TW'(0));
        rd_n++;
        outstanding = 1'b1;
        pending = pick_lat(lat_sel, rd_n);
        new_rd = 1'b1;
      end

      if (done) begin
        if (tiles > 0) check_eq("done_latency", TW'(cyc), TW'(last_wr_cyc + 1));
        else           check_eq("done_latency_zero", TW'(cyc), TW'(start_cyc + 2));
        check_eq("rd_count", TW'(rd_n), TW'(tiles));
        check_eq("wr_count", TW'(wr_n), TW'(tiles));
        got_done = 1'b1;
      end

      if (reset_mid && wr_n == 1) begin
        vec_read_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        tick();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
          tick();
          check_eq("post_reset_done", TW'(done), '0);
          check_eq("post_reset_rd", TW'(vec_read_enable), '0);
          check_eq("post_reset_wr", TW'(vec_write_enable), '0);
        end
        return;
      end

      // drive the buffer-controller response for the coming edge
      vec_read_valid = 1'b0;
      if (!new_rd && pending > 0) begin
        pending--;
        if (pending == 0) begin
          vec_read_valid = 1'b1;
          vec_read_tile  = srcq[rd_n-1];
          valid_cyc      = cyc;
          outstanding    = 1'b0;
        end
      end

      if (spurious_start && !spur_done && rd_n == 1) begin
        start          = 1'b1;
        op_mode        = ~mode;
        src_buffer_id  = src ^ 5'h1f;
        dest_buffer_id = dst ^ 5'h1f;
        length         = 10'($urandom_range(1, 1023));
        spur_done      = 1'b1;
      end
    end

    if (!got_done) check_eq("timeout_done", TW'(0), TW'(1));
    tick();
    check_eq("busy_low_after", TW'(busy), '0);
    check_eq("done_single", TW'(done), '0);
    if (tiles > 0) check_eq("wr_tile_hold", vec_write_tile, expq[tiles-1]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_mode = 1'b0; src_buffer_id = '0; dest_buffer_id = '0;
    length = '0; vec_read_tile = '0; vec_read_valid = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    run_op(10, 1'b0, 5'd3, 5'd7, 0, 1'b1, 1'b0, 1'b0);
    run_op(70, 1'b0, 5'd4, 5'd9, 1, 1'b0, 1'b0, 1'b0);
    run_op(64, 1'b1, 5'd5, 5'd10, 2, 1'b0, 1'b0, 1'b0);
    run_op(0,  1'b0, 5'd6, 5'd12, 2, 1'b0, 1'b0, 1'b0);

    // stray valid while idle must not produce a write
    vec_read_valid = 1'b1;
    vec_read_tile  = {8{32'($urandom)}};
    tick();
    vec_read_valid = 1'b0;
    tick();
    check_eq("idle_valid_no_wr", TW'(vec_write_enable), '0);
    check_eq("idle_valid_no_done", TW'(done), '0);
    run_op(40, 1'b0, 5'd6, 5'd11, 2, 1'b0, 1'b1, 1'b0);

    run_op(96, 1'b0, 5'd8, 5'd13, 2, 1'b0, 1'b0, 1'b1);
    run_op(32, 1'b0, 5'd8, 5'd13, 2, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      run_op(int'($urandom_range(0, 1023)), 1'($urandom), 5'($urandom), 5'($urandom),
             2, 1'b0, 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
